// File: rtl/icache_tag_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// icache_tag_pkg
//   Shared types and sizes for the icache tag port controller.
//   - SET_IDX_WIDTH / TAG_WIDTH : geometry of the 16 x 24 tag SRAM
//   - tag_entry_t               : SRAM word layout {valid, tag}
//   - ctrl_state_t              : controller state (CLEAR sweep / RUN)
//   - lookup_stage_t            : lookup captured at acceptance, used to form
//                                 the response one cycle later
// ----------------------------------------------------------------------------
package icache_tag_pkg;

   localparam int SET_IDX_WIDTH = 4;
   localparam int TAG_WIDTH     = 23;
   localparam int NUM_SETS      = 1 << SET_IDX_WIDTH;
   localparam int ENTRY_WIDTH   = TAG_WIDTH + 1;

   typedef struct packed {
      logic                 valid;
      logic [TAG_WIDTH-1:0] tag;
   } tag_entry_t;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } ctrl_state_t;

   typedef struct packed {
      logic                     valid;
      logic [SET_IDX_WIDTH-1:0] set;
      logic [TAG_WIDTH-1:0]     tag;
   } lookup_stage_t;

   function automatic logic entry_hit(tag_entry_t e, logic [TAG_WIDTH-1:0] t);
      return e.valid && (e.tag == t);
   endfunction

endpackage

// File: rtl/icache_tag_ctrl_if.sv
// ----------------------------------------------------------------------------
// icache_tag_ctrl_if
//   Request/response bundle between the icache datapath (master) and the tag
//   port controller (slave).
//   lookup_valid/ready, lookup_set, lookup_tag : lookup request handshake
//   resp_valid, resp_hit, resp_set             : lookup result, no backpressure
//   fill_valid/ready, fill_set, fill_tag       : fill request handshake
//   flush                                      : one-cycle invalidate-all pulse
//   init_done                                  : clear sweep has completed
// ----------------------------------------------------------------------------
interface icache_tag_ctrl_if;
   import icache_tag_pkg::*;

   logic                     lookup_valid;
   logic                     lookup_ready;
   logic [SET_IDX_WIDTH-1:0] lookup_set;
   logic [TAG_WIDTH-1:0]     lookup_tag;

   logic                     resp_valid;
   logic                     resp_hit;
   logic [SET_IDX_WIDTH-1:0] resp_set;

   logic                     fill_valid;
   logic                     fill_ready;
   logic [SET_IDX_WIDTH-1:0] fill_set;
   logic [TAG_WIDTH-1:0]     fill_tag;

   logic                     flush;
   logic                     init_done;

   modport master (
      output lookup_valid, lookup_set, lookup_tag,
      output fill_valid, fill_set, fill_tag,
      output flush,
      input  lookup_ready, fill_ready,
      input  resp_valid, resp_hit, resp_set,
      input  init_done
   );

   modport slave (
      input  lookup_valid, lookup_set, lookup_tag,
      input  fill_valid, fill_set, fill_tag,
      input  flush,
      output lookup_ready, fill_ready,
      output resp_valid, resp_hit, resp_set,
      output init_done
   );

endinterface

// File: rtl/icache_tag_array.sv
// ----------------------------------------------------------------------------
// icache_tag_array
//   Behavioural model of the single-port tag SRAM macro. Inputs are captured
//   on the rising edge of clk0; the write or read is carried out on the
//   following falling edge. No reset: contents are undefined until written.
//   clk0  : clock
//   csb0  : chip select, active low
//   web0  : write enable, active low
//   addr0 : word address
//   din0  : write data
//   dout0 : read data, updated at the falling edge after a captured read
// ----------------------------------------------------------------------------
module icache_tag_array #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 24
) (
   input  logic                  clk0,
   input  logic                  csb0,
   input  logic                  web0,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [DATA_WIDTH-1:0] din0,
   output logic [DATA_WIDTH-1:0] dout0
);

   logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
   logic                  r_csb;
   logic                  r_web;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_din;

   always_ff @(posedge clk0) begin
      r_csb  <= csb0;
      r_web  <= web0;
      r_addr <= addr0;
      r_din  <= din0;
   end

   always_ff @(negedge clk0) begin
      if (!r_csb && !r_web) begin
         r_mem[r_addr] <= r_din;
      end
   end

   always_ff @(negedge clk0) begin
      if (!r_csb && r_web) begin
         dout0 <= r_mem[r_addr];
      end
   end

endmodule

// File: rtl/icache_tag_ctrl.sv
// ----------------------------------------------------------------------------
// icache_tag_ctrl
//   Owns the single RW port of the icache tag SRAM. After reset, and after
//   every flush, it sweeps all sets writing an invalid entry. In RUN it
//   serialises flush > fill > lookup onto the port and returns hit/miss one
//   cycle after each accepted lookup.
//
//   clk        : clock, shared with the SRAM clk0
//   rst        : asynchronous, active-high reset
//   bus        : request/response bundle (slave side)
//   sram_csb0  : SRAM chip select, active low
//   sram_web0  : SRAM write enable, active low
//   sram_addr0 : SRAM address
//   sram_din0  : SRAM write data {valid, tag}
//   sram_dout0 : SRAM read data
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   CLEAR | writing an invalid entry to set r_clr_cnt, 0 -> 15; no traffic
//   RUN   | normal service; flush restarts the sweep
// ----------------------------------------------------------------------------
module icache_tag_ctrl
   import icache_tag_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   icache_tag_ctrl_if.slave         bus,
   output logic                     sram_csb0,
   output logic                     sram_web0,
   output logic [SET_IDX_WIDTH-1:0] sram_addr0,
   output logic [ENTRY_WIDTH-1:0]   sram_din0,
   input  logic [ENTRY_WIDTH-1:0]   sram_dout0
);

   ctrl_state_t              r_state;
   logic [SET_IDX_WIDTH-1:0] r_clr_cnt;
   logic                     r_init_done;
   lookup_stage_t            r_stage;

   ctrl_state_t              w_state_nxt;
   logic [SET_IDX_WIDTH-1:0] w_clr_cnt_nxt;
   logic                     w_init_done_nxt;
   lookup_stage_t            w_stage_nxt;

   logic                     w_fill_ready;
   logic                     w_lookup_ready;
   logic                     w_fill_acc;
   logic                     w_lookup_acc;

   logic                     w_csb;
   logic                     w_web;
   logic [SET_IDX_WIDTH-1:0] w_addr;
   tag_entry_t               w_din;
   tag_entry_t               w_rd_entry;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= CLEAR;
         r_clr_cnt   <= '0;
         r_init_done <= 1'b0;
         r_stage     <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_clr_cnt   <= w_clr_cnt_nxt;
         r_init_done <= w_init_done_nxt;
         r_stage     <= w_stage_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_clr_cnt_nxt   = r_clr_cnt;
      w_init_done_nxt = r_init_done;
      w_stage_nxt     = '0;
      w_fill_ready    = 1'b0;
      w_lookup_ready  = 1'b0;
      w_fill_acc      = 1'b0;
      w_lookup_acc    = 1'b0;
      w_csb           = 1'b1;
      w_web           = 1'b1;
      w_addr          = '0;
      w_din           = '0;

      case (r_state)
         CLEAR: begin
            // flush is ignored here; the sweep simply runs to completion
            w_csb  = 1'b0;
            w_web  = 1'b0;
            w_addr = r_clr_cnt;
            w_din  = '0;
            if (&r_clr_cnt) begin
               w_state_nxt     = RUN;
               w_init_done_nxt = 1'b1;
               w_clr_cnt_nxt   = '0;
            end else begin
               w_clr_cnt_nxt = r_clr_cnt + 1'b1;
            end
         end

         RUN: begin
            w_fill_ready   = !bus.flush;
            w_lookup_ready = !bus.flush && !bus.fill_valid;
            w_fill_acc     = w_fill_ready && bus.fill_valid;
            w_lookup_acc   = w_lookup_ready && bus.lookup_valid;

            if (bus.flush) begin
               w_state_nxt     = CLEAR;
               w_clr_cnt_nxt   = '0;
               w_init_done_nxt = 1'b0;
            end else if (w_fill_acc) begin
               w_csb  = 1'b0;
               w_web  = 1'b0;
               w_addr = bus.fill_set;
               w_din  = '{valid: 1'b1, tag: bus.fill_tag};
            end else if (w_lookup_acc) begin
               w_csb       = 1'b0;
               w_web       = 1'b1;
               w_addr      = bus.lookup_set;
               w_stage_nxt = '{valid: 1'b1, set: bus.lookup_set, tag: bus.lookup_tag};
            end
         end

         default: begin
            w_state_nxt = CLEAR;
         end
      endcase

      // During reset the state register already reads CLEAR, which would
      // otherwise drive a clear write; keep the macro deselected instead.
      if (rst) begin
         w_csb  = 1'b1;
         w_web  = 1'b1;
         w_addr = '0;
         w_din  = '0;
      end
   end

   assign sram_csb0  = w_csb;
   assign sram_web0  = w_web;
   assign sram_addr0 = w_addr;
   assign sram_din0  = w_din;

   assign bus.fill_ready   = w_fill_ready;
   assign bus.lookup_ready = w_lookup_ready;
   assign bus.init_done    = r_init_done;

   // Gating with the stage valid keeps undefined SRAM data off resp_hit.
   assign w_rd_entry     = tag_entry_t'(sram_dout0);
   assign bus.resp_valid = r_stage.valid;
   assign bus.resp_hit   = r_stage.valid & entry_hit(w_rd_entry, r_stage.tag);
   assign bus.resp_set   = r_stage.valid ? r_stage.set : '0;

endmodule

// File: tb/tb_icache_tag_ctrl.sv
module tb_icache_tag_ctrl;
   import icache_tag_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        sram_csb0;
   logic        sram_web0;
   logic [3:0]  sram_addr0;
   logic [23:0] sram_din0;
   logic [23:0] sram_dout0;

   icache_tag_ctrl_if bus();

   icache_tag_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .sram_csb0  (sram_csb0),
      .sram_web0  (sram_web0),
      .sram_addr0 (sram_addr0),
      .sram_din0  (sram_din0),
      .sram_dout0 (sram_dout0)
   );

   icache_tag_array #(.ADDR_WIDTH(4), .DATA_WIDTH(24)) u_sram (
      .clk0  (clk),
      .csb0  (sram_csb0),
      .web0  (sram_web0),
      .addr0 (sram_addr0),
      .din0  (sram_din0),
      .dout0 (sram_dout0)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   // reference model: abstract cache contents plus cycles left in the sweep
   bit          m_valid [16];
   logic [22:0] m_tag   [16];
   int          clear_left = 16;

   typedef struct packed {
      logic [3:0] set;
      logic       hit;
   } exp_t;
   exp_t exp_q[$];
   bit   mon_en = 1'b0;

   task automatic invalidate_model();
      for (int i = 0; i < 16; i++) begin
         m_valid[i] = 1'b0;
         m_tag[i]   = '0;
      end
   endtask

   // Response monitor: samples late in the cycle, after the SRAM read edge.
   always begin
      @(negedge clk);
      #2;
      if (mon_en) begin
         if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("resp_valid", {31'b0, bus.resp_valid}, 32'd1);
            chk("resp_set",   {28'b0, bus.resp_set},   {28'b0, e.set});
            chk("resp_hit",   {31'b0, bus.resp_hit},   {31'b0, e.hit});
         end else begin
            chk("resp_valid_idle", {31'b0, bus.resp_valid}, 32'd0);
            chk("resp_hit_idle",   {31'b0, bus.resp_hit},   32'd0);
            chk("resp_set_idle",   {28'b0, bus.resp_set},   32'd0);
         end
      end
   end

   task automatic set_idle_inputs();
      bus.lookup_valid = 1'b0;
      bus.lookup_set   = '0;
      bus.lookup_tag   = '0;
      bus.fill_valid   = 1'b0;
      bus.fill_set     = '0;
      bus.fill_tag     = '0;
      bus.flush        = 1'b0;
   endtask

   task automatic check_sram_idle(string tag);
      chk({tag, "_csb0"}, {31'b0, sram_csb0}, 32'd1);
      chk({tag, "_web0"}, {31'b0, sram_web0}, 32'd1);
      chk({tag, "_addr0"}, {28'b0, sram_addr0}, 32'd0);
      chk({tag, "_din0"}, {8'b0, sram_din0}, 32'd0);
   endtask

   // One clock of stimulus; called #1 after a posedge.
   task automatic step(input logic lv, input logic [3:0] ls, input logic [22:0] lt,
                       input logic fv, input logic [3:0] fs, input logic [22:0] ft,
                       input logic fl);
      bit run, exp_fr, exp_lr;
      bus.lookup_valid = lv;
      bus.lookup_set   = ls;
      bus.lookup_tag   = lt;
      bus.fill_valid   = fv;
      bus.fill_set     = fs;
      bus.fill_tag     = ft;
      bus.flush        = fl;
      run    = (clear_left == 0);
      exp_fr = run && !fl;
      exp_lr = exp_fr && !fv;

      @(negedge clk);
      chk("fill_ready",   {31'b0, bus.fill_ready},   {31'b0, exp_fr});
      chk("lookup_ready", {31'b0, bus.lookup_ready}, {31'b0, exp_lr});
      chk("init_done",    {31'b0, bus.init_done},    {31'b0, run});
      if (!run) begin
         chk("clr_csb0", {31'b0, sram_csb0}, 32'd0);
         chk("clr_web0", {31'b0, sram_web0}, 32'd0);
         chk("clr_addr0", {28'b0, sram_addr0}, 32'(16 - clear_left));
         chk("clr_din0", {8'b0, sram_din0}, 32'd0);
      end else if (fl || !(fv || lv)) begin
         check_sram_idle("idle");
      end else if (fv) begin
         chk("fill_csb0", {31'b0, sram_csb0}, 32'd0);
         chk("fill_web0", {31'b0, sram_web0}, 32'd0);
         chk("fill_addr0", {28'b0, sram_addr0}, {28'b0, fs});
         chk("fill_din0", {8'b0, sram_din0}, {8'b0, 1'b1, ft});
      end else begin
         chk("rd_csb0", {31'b0, sram_csb0}, 32'd0);
         chk("rd_web0", {31'b0, sram_web0}, 32'd1);
         chk("rd_addr0", {28'b0, sram_addr0}, {28'b0, ls});
      end

      @(posedge clk);
      if (!run) begin
         clear_left--;
      end else if (fl) begin
         clear_left = 16;
         invalidate_model();
      end else if (fv) begin
         m_valid[fs] = 1'b1;
         m_tag[fs]   = ft;
      end else if (lv) begin
         exp_q.push_back('{set: ls, hit: (m_valid[ls] && m_tag[ls] == lt)});
      end
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 4'd0, 23'd0, 1'b0, 4'd0, 23'd0, 1'b0);
   endtask

   task automatic lookup(input logic [3:0] s, input logic [22:0] t);
      step(1'b1, s, t, 1'b0, 4'd0, 23'd0, 1'b0);
   endtask

   task automatic fill(input logic [3:0] s, input logic [22:0] t);
      step(1'b0, 4'd0, 23'd0, 1'b1, s, t, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      set_idle_inputs();
      mon_en = 1'b1;
      @(negedge clk);
      check_sram_idle("rst");
      chk("rst_lookup_ready", {31'b0, bus.lookup_ready}, 32'd0);
      chk("rst_fill_ready",   {31'b0, bus.fill_ready},   32'd0);
      chk("rst_init_done",    {31'b0, bus.init_done},    32'd0);
      chk("rst_resp_valid",   {31'b0, bus.resp_valid},   32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      clear_left = 16;
      invalidate_model();
   endtask

   logic [22:0] tag_pool [4];

   initial begin
      set_idle_inputs();
      invalidate_model();
      #1;

      // reset sweep, then every set misses
      do_reset();
      idle(16);
      for (int i = 0; i < 16; i++) lookup(4'(i), 23'($urandom));

      // miss, fill, hit, tag mismatch
      lookup(4'd5, 23'h12345);
      fill(4'd5, 23'h12345);
      lookup(4'd5, 23'h12345);
      lookup(4'd5, 23'h12346);

      // back-to-back lookups around a filled set
      fill(4'd2, 23'h0abcde);
      lookup(4'd0, 23'h0abcde);
      lookup(4'd1, 23'h0abcde);
      lookup(4'd2, 23'h0abcde);
      lookup(4'd3, 23'h0abcde);

      // fill and lookup together: fill wins, lookup goes next cycle
      step(1'b1, 4'd9, 23'h777, 1'b1, 4'd9, 23'h777, 1'b0);
      lookup(4'd9, 23'h777);

      // flush with a lookup in flight
      fill(4'd7, 23'h3f00f);
      lookup(4'd7, 23'h3f00f);
      step(1'b0, 4'd0, 23'd0, 1'b0, 4'd0, 23'd0, 1'b1);
      idle(16);
      lookup(4'd7, 23'h3f00f);
      lookup(4'd5, 23'h12345);

      // reset in the middle of a sweep (clr_cnt = 9)
      fill(4'd4, 23'h444);
      step(1'b0, 4'd0, 23'd0, 1'b0, 4'd0, 23'd0, 1'b1);
      idle(9);
      do_reset();
      idle(16);
      lookup(4'd4, 23'h444);

      // randomized traffic
      tag_pool[0] = 23'h000001;
      tag_pool[1] = 23'h155555;
      tag_pool[2] = 23'h2aaaaa;
      tag_pool[3] = 23'(($urandom));
      for (int n = 0; n < 500; n++) begin
         logic lv, fv, fl;
         logic [3:0] ls, fs;
         logic [22:0] lt, ft;
         lv = ($urandom_range(0, 3) != 0);
         fv = ($urandom_range(0, 3) == 0);
         fl = ($urandom_range(0, 59) == 0);
         ls = 4'($urandom_range(0, 7));
         fs = 4'($urandom_range(0, 7));
         lt = tag_pool[$urandom_range(0, 3)];
         ft = tag_pool[$urandom_range(0, 3)];
         step(lv, ls, lt, fv, fs, ft, fl);
      end

      idle(3);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/icache_tag_ctrl.md
# icache_tag_ctrl

Port controller that owns the single RW port of the 16×24 icache tag SRAM (`icache_tag_array`) and returns hit/miss per lookup. Because the SRAM has no reset, the controller clears every entry after reset and on flush. It accepts fills from the miss path and serialises flush, fill and lookup traffic onto the one port. It sits between the icache datapath/FSM and the tag array macro.

## Interface
- SET_IDX_WIDTH, 4: set index width; the array holds 16 sets.
- TAG_WIDTH, 23: tag width. SRAM entry is {valid[23], tag[22:0]}.
- clk  in  1  single clock, shared with the SRAM's clk0.
- rst  in  1  reset; asynchronous, active-high.
- lookup_valid / lookup_ready  in/out  1 / 1  lookup handshake.
- lookup_set / lookup_tag  in  4 / 23  lookup set and tag.
- resp_valid  out  1  lookup result strobe; no backpressure.
- resp_hit  out  1  stored entry is valid and its tag matches.
- resp_set  out  4  set of the responding lookup.
- fill_valid / fill_ready  in/out  1 / 1  fill handshake.
- fill_set / fill_tag  in  4 / 23  fill writes {1, fill_tag} to fill_set.
- flush  in  1  one-cycle pulse; invalidates all sets.
- init_done  out  1  high once the clear sweep completes.
- sram_csb0 / sram_web0  out  1 / 1  active-low chip select / write enable.
- sram_addr0 / sram_din0  out  4 / 24  SRAM address and write data.
- sram_dout0  in  24  SRAM read data.

## Operation
- **States**
  - CLEAR: write 0 to set clr_cnt each cycle, clr_cnt 0→15.
  - RUN: normal service.
- **State transitions**
  - Reset enters CLEAR with clr_cnt=0.
  - CLEAR → RUN after the set-15 write is captured; init_done is set at the same time.
  - RUN → CLEAR on flush; clr_cnt=0 and init_done clears.
  - flush while already in CLEAR is ignored; the sweep is not restarted.
- **Port priority in RUN:** flush > fill > lookup.
  - fill_ready = state==RUN && !flush.
  - lookup_ready = state==RUN && !flush && !fill_valid.
  - In CLEAR, both readies are 0.
- **SRAM drive** (combinational from state and the accepted request, so the SRAM captures it on the same posedge):
  - Write: csb0=0, web0=0, addr, din.
  - Read: csb0=0, web0=1, addr=lookup_set.
  - Idle: csb0=1, web0=1, addr=0, din=0.
- **Lookup stage register:** captures {valid, set, tag} at acceptance. In the following cycle:
  - resp_valid = stage.valid.
  - resp_hit = sram_dout0[23] && sram_dout0[22:0]==stage.tag.
  - resp_set = stage.set.
- **Output qualification:** resp_hit and resp_set are 0 whenever resp_valid is 0, so SRAM X data never propagates.
- **Flush with a lookup in flight:** a lookup accepted in the same cycle as flush is impossible (lookup_ready=0). A lookup accepted the cycle before flush still responds, with pre-flush contents.
- **Fill followed by lookup to the same set:** a lookup accepted the cycle after a fill observes the filled entry. The SRAM writes at the negedge after capture, and the read occurs one negedge later.
- **Reset mid-operation:** rst forces csb0=1, web0=1, clears the stage register, resp_valid=0, init_done=0. The sweep restarts from set 0 after release. A partial sweep is never considered complete.

## Timing
- **Reset values:** lookup_ready=0, fill_ready=0, resp_valid=0, resp_hit=0, resp_set=0, init_done=0, sram_csb0=1, sram_web0=1, sram_addr0=0, sram_din0=0.
- **Clear sweep:** the first clear write is captured at the first posedge after rst falls. init_done rises after the 16th posedge. lookup_ready can be 1 in the following cycle.
- **Lookup latency:** handshake at posedge E → resp_valid high for exactly the cycle between E and E+1.
- **Throughput:** one lookup per cycle with back-to-back lookups.
- **Fill:** one cycle per fill; no response is produced.
- **Flush cost:** 16 cycles, during which both readies are 0.
- resp_* are combinational from the stage register and sram_dout0. The consumer samples them at posedge E+1.

## Structure
- **Package icache_tag_pkg:**
  - SET_IDX_WIDTH, TAG_WIDTH.
  - Packed typedef tag_entry_t {valid, tag}.
  - Enum ctrl_state_t {CLEAR, RUN}.
  - Lookup stage struct.
- **Sub-modules:** none. The SRAM macro is instantiated by the parent; the bench instantiates icache_tag_array beside the DUT.

## Test plan
- **Reset sweep:** release rst → csb0=0, web0=0, din=0 for addr 0..15 on consecutive cycles. Then init_done=1 and lookup_ready=1. All 16 lookups then return resp_hit=0.
- **Miss, fill, hit:** lookup set 5, tag 0x12345 → resp_hit=0. Fill set 5, tag 0x12345, then lookup set 5, tag 0x12345 the next cycle → resp_hit=1. Lookup set 5, tag 0x12346 → resp_hit=0.
- **Back-to-back lookups:** lookups to sets 0,1,2,3 on consecutive cycles after filling set 2 → resp_valid held for 4 cycles, resp_set=0,1,2,3, resp_hit=0,0,1,0.
- **Fill and lookup conflict:** fill_valid and lookup_valid high together → fill accepted, lookup_ready=0. The lookup is accepted on the next cycle.
- **Flush mid-stream:** fill set 7; accept a lookup on set 7; pulse flush the next cycle. The in-flight lookup returns hit=1, then 16 clear cycles run. A lookup on set 7 afterwards returns hit=0.
- **Reset mid-sweep:** assert rst at clr_cnt=9 → csb0=1 immediately. After release the sweep restarts at addr 0, and init_done rises only after 16 further writes.
